// File: rtl/spi_word_master.sv
// SPI word master: sends WORD_W-bit words MSB first on sdo/sck with an
// active-high frame select, a one-entry holding buffer for back-to-back
// words, and a programmable cs-low gap between frames.
module spi_word_master #(
   parameter int CLK_DIV = 4,
   parameter int WORD_W  = 16,
   parameter int GAP_HP  = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              tx_valid,
   input  logic [WORD_W-1:0] tx_data,
   output logic              tx_ready,
   output logic              sck,
   output logic              sdo,
   output logic              cs,
   output logic              done,
   output logic              busy
);

   localparam int BIT_W = $clog2(WORD_W) + 1;

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] LEAD = 3'd1;
   localparam logic [2:0] HIGH = 3'd2;
   localparam logic [2:0] LOW  = 3'd3;
   localparam logic [2:0] GAP  = 3'd4;

   localparam logic [7:0]       DIV_LAST = 8'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W - 1);
   localparam logic [3:0]       GAP_LAST = 4'(GAP_HP - 1);

   logic [2:0]        state;
   logic [7:0]        div_cnt;
   logic [BIT_W-1:0]  bit_cnt;
   logic [3:0]        hp_cnt;
   logic              buf_full;
   logic [WORD_W-1:0] buf_data;
   logic [WORD_W-1:0] shift;
   logic              accept;
   logic              div_end;

   assign tx_ready = !buf_full;
   assign accept   = tx_valid && tx_ready;
   assign div_end  = (div_cnt == DIV_LAST);

   // Phase sequencing: divider counts system clocks inside each phase,
   // bit counter counts sck periods, hp counter counts gap half-periods.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         div_cnt <= 8'd0;
         bit_cnt <= '0;
         hp_cnt  <= 4'd0;
      end else begin
         case (state)
            IDLE: begin
               if (buf_full || accept) begin
                  state   <= LEAD;
                  div_cnt <= 8'd0;
                  bit_cnt <= '0;
               end
            end
            LEAD: begin
               if (div_end) begin
                  state   <= HIGH;
                  div_cnt <= 8'd0;
               end else begin
                  div_cnt <= div_cnt + 8'd1;
               end
            end
            HIGH: begin
               if (div_end) begin
                  state   <= LOW;
                  div_cnt <= 8'd0;
               end else begin
                  div_cnt <= div_cnt + 8'd1;
               end
            end
            LOW: begin
               if (div_end) begin
                  div_cnt <= 8'd0;
                  if (bit_cnt == BIT_LAST) begin
                     state   <= GAP;
                     bit_cnt <= '0;
                     hp_cnt  <= 4'd0;
                  end else begin
                     state   <= HIGH;
                     bit_cnt <= bit_cnt + BIT_W'(1);
                  end
               end else begin
                  div_cnt <= div_cnt + 8'd1;
               end
            end
            GAP: begin
               if (div_end) begin
                  div_cnt <= 8'd0;
                  if (hp_cnt == GAP_LAST) begin
                     state  <= IDLE;
                     hp_cnt <= 4'd0;
                  end else begin
                     hp_cnt <= hp_cnt + 4'd1;
                  end
               end else begin
                  div_cnt <= div_cnt + 8'd1;
               end
            end
            default: begin
               state   <= IDLE;
               div_cnt <= 8'd0;
               bit_cnt <= '0;
               hp_cnt  <= 4'd0;
            end
         endcase
      end
   end

   // Holding-buffer occupancy: drained into the shifter from IDLE, filled
   // by any word accepted while a frame (or its gap) is in progress.
   always_ff @(posedge clk) begin
      if (reset) begin
         buf_full <= 1'b0;
      end else if (state == IDLE && buf_full) begin
         buf_full <= 1'b0;
      end else if (accept && state != IDLE) begin
         buf_full <= 1'b1;
      end
   end

   // Data path: load the shifter at frame start, shift on entry to LOW so
   // sdo only moves while sck is low; capture buffered words.
   always_ff @(posedge clk) begin
      if (state == IDLE) begin
         if (buf_full) begin
            shift <= buf_data;
         end else if (accept) begin
            shift <= tx_data;
         end
      end else if (state == HIGH && div_end) begin
         shift <= {shift[WORD_W-2:0], 1'b0};
      end
      if (accept && state != IDLE) begin
         buf_data <= tx_data;
      end
   end

   // Output decode from the phase; sdo is forced low outside the frame.
   always_comb begin
      cs   = (state == LEAD) || (state == HIGH) || (state == LOW);
      sck  = (state == HIGH);
      sdo  = cs && shift[WORD_W-1];
      done = (state == GAP) && (div_cnt == 8'd0) && (hp_cnt == 4'd0);
      busy = (state != IDLE);
   end

endmodule

// File: tb/tb_spi_word_master.sv
// Bench for spi_word_master: a frame-timeline reference model plus a
// sampling receiver, with directed scenarios followed by random traffic.
module tb_spi_word_master;

   localparam int D     = 4;
   localparam int W     = 16;
   localparam int G     = 2;
   localparam int FRAME = (2 * W + 1) * D;
   localparam int TOTAL = FRAME + G * D;

   logic          clk = 1'b0;
   logic          reset;
   logic          tx_valid;
   logic [W-1:0]  tx_data;
   logic          tx_ready, sck, sdo, cs, done, busy;

   spi_word_master #(.CLK_DIV(D), .WORD_W(W), .GAP_HP(G)) dut (
      .clk(clk), .reset(reset), .tx_valid(tx_valid), .tx_data(tx_data),
      .tx_ready(tx_ready), .sck(sck), .sdo(sdo), .cs(cs), .done(done), .busy(busy)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // model state: frame timeline position, current word, pending word
   bit           m_init = 0;
   bit           m_active = 0;
   int           m_t = 0;
   logic [W-1:0] m_word = '0;
   bit           m_pend = 0;
   logic [W-1:0] m_pend_word = '0;
   bit           m_abort = 0;
   logic [W-1:0] exp_q[$];

   // receiver observations
   logic [W-1:0] rx_bits = '0;
   logic [W-1:0] last_rx = '0;
   int           rises = 0, cs_len = 0, last_len = 0, last_rises = 0;
   int           frames = 0, done_total = 0;
   logic         prev_cs = 1'b0, prev_sck = 1'b0, prev_sdo = 1'b0;

   initial begin : model_and_check
      bit   acc;
      int   j;
      logic e_cs, e_sck, e_sdo, e_done;
      logic [W-1:0] got;
      forever begin
         @(posedge clk);
         if (reset) begin
            if (m_active && m_t < FRAME) m_abort = 1;
            m_init = 1; m_active = 0; m_t = 0; m_pend = 0;
            exp_q.delete();
         end else begin
            acc = tx_valid && !m_pend;
            if (!m_active) begin
               if (m_pend) begin
                  m_word = m_pend_word; m_pend = 0; m_active = 1; m_t = 0;
                  exp_q.push_back(m_word);
               end else if (acc) begin
                  m_word = tx_data; m_active = 1; m_t = 0;
                  exp_q.push_back(m_word);
               end
            end else begin
               if (acc) begin m_pend = 1; m_pend_word = tx_data; end
               m_t++;
               if (m_t == TOTAL) begin m_active = 0; m_t = 0; end
            end
         end
         @(negedge clk);
         if (m_init) begin
            e_cs   = m_active && (m_t < FRAME);
            e_sck  = e_cs && (m_t >= D) && (((m_t - D) / D) % 2 == 0);
            j      = (m_t < 2 * D) ? 0 : (m_t - 2 * D) / (2 * D) + 1;
            e_sdo  = (e_cs && j < W) ? m_word[W-1-j] : 1'b0;
            e_done = m_active && (m_t == FRAME);
            chk("cs", 32'(cs), 32'(e_cs));
            chk("sck", 32'(sck), 32'(e_sck));
            chk("sdo", 32'(sdo), 32'(e_sdo));
            chk("done", 32'(done), 32'(e_done));
            chk("busy", 32'(busy), 32'(m_active));
            chk("tx_ready", 32'(tx_ready), 32'(!m_pend));
            if (cs && !prev_cs) begin rx_bits = '0; rises = 0; cs_len = 0; end
            if (cs) cs_len++;
            if (cs && sck && !prev_sck) begin rx_bits = {rx_bits[W-2:0], sdo}; rises++; end
            if (sck && prev_sck) chk("sdo_stable_sck_high", 32'(sdo), 32'(prev_sdo));
            if (!cs && prev_cs) begin
               if (m_abort) begin
                  m_abort = 0;
               end else begin
                  last_rx = rx_bits; last_len = cs_len; last_rises = rises; frames++;
                  got = (exp_q.size() > 0) ? exp_q.pop_front() : ~rx_bits;
                  chk("rx_word", 32'(rx_bits), 32'(got));
                  chk("cs_high_len", 32'(cs_len), 32'(FRAME));
                  chk("sck_rises", 32'(rises), 32'(W));
               end
            end
            if (done) done_total++;
         end
         prev_cs = cs; prev_sck = sck; prev_sdo = sdo;
      end
   end

   task automatic offer(input logic [W-1:0] w);
      int n = 0;
      tx_valid = 1'b1; tx_data = w;
      while (!tx_ready && n < 2000) begin @(posedge clk); #1; n++; end
      if (n >= 2000) chk("offer_timeout", 32'(tx_ready), 32'd1);
      @(posedge clk); #1;
      tx_valid = 1'b0; tx_data = W'($urandom);
   endtask

   task automatic wait_done();
      int n = 0;
      do begin @(posedge clk); #1; n++; end while (!done && n < 2000);
      if (!done) chk("done_timeout", 32'(done), 32'd1);
   endtask

   initial begin : stimulus
      int cnt, f0, d0;
      reset = 1'b1; tx_valid = 1'b0; tx_data = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      chk("rst_tx_ready", 32'(tx_ready), 32'd1);
      chk("rst_cs", 32'(cs), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_sck_sdo", 32'({sck, sdo, done}), 32'd0);

      // single MSB-only word
      offer(16'h8000);
      wait_done();
      repeat (2) @(posedge clk); #1;
      chk("f8000_word", 32'(last_rx), 32'h8000);
      chk("f8000_cs_len", 32'(last_len), 32'd132);
      chk("f8000_rises", 32'(last_rises), 32'd16);
      repeat (20) @(posedge clk); #1;

      // two words, second buffered
      offer(16'h4000); offer(16'h2000);
      wait_done();
      repeat (2) @(posedge clk); #1;
      chk("f4000_word", 32'(last_rx), 32'h4000);
      wait_done();
      repeat (2) @(posedge clk); #1;
      chk("f2000_word", 32'(last_rx), 32'h2000);
      repeat (20) @(posedge clk); #1;

      // buffer full: third offer ignored, 9-cycle cs-low gap
      offer(16'h1234); offer(16'hA5C3);
      tx_valid = 1'b1; tx_data = 16'h5555;
      chk("third_offer_ready", 32'(tx_ready), 32'd0);
      @(posedge clk); #1 tx_valid = 1'b0;
      f0 = frames;
      wait_done();
      cnt = 1;
      while (!cs && cnt < 100) begin @(posedge clk); #1; if (!cs) cnt++; end
      chk("gap_cs_low", 32'(cnt), 32'd9);
      wait_done();
      repeat (2) @(posedge clk); #1;
      chk("fA5C3_word", 32'(last_rx), 32'hA5C3);
      repeat (200) @(posedge clk); #1;
      chk("third_not_sent", 32'(frames - f0), 32'd2);

      // reset mid-frame with a buffered word
      d0 = done_total; f0 = frames;
      offer(16'h0F0F); offer(16'h7777);
      cnt = 0;
      while (rises != 8 && cnt < 2000) begin @(posedge clk); #1; cnt++; end
      chk("reach_8th_rise", 32'(rises), 32'd8);
      reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      chk("abort_cs", 32'(cs), 32'd0);
      chk("abort_sck", 32'(sck), 32'd0);
      chk("abort_tx_ready", 32'(tx_ready), 32'd1);
      repeat (300) @(posedge clk); #1;
      chk("abort_no_done", 32'(done_total - d0), 32'd0);
      chk("abort_no_frame", 32'(frames - f0), 32'd0);

      // all ones then all zeros
      d0 = done_total;
      offer(16'hFFFF); offer(16'h0000);
      wait_done();
      repeat (2) @(posedge clk); #1;
      chk("fFFFF_word", 32'(last_rx), 32'hFFFF);
      wait_done();
      repeat (20) @(posedge clk); #1;
      chk("f0000_word", 32'(last_rx), 32'h0000);
      chk("done_per_frame", 32'(done_total - d0), 32'd2);

      // random traffic, including offers that may be refused
      for (int i = 0; i < 30; i++) begin
         repeat ($urandom_range(0, 150)) @(posedge clk);
         #1;
         if ($urandom_range(0, 2) == 0) begin
            tx_valid = 1'b1; tx_data = W'($urandom);
            @(posedge clk); #1 tx_valid = 1'b0;
         end else begin
            offer(W'($urandom));
         end
      end
      cnt = 0;
      while ((busy || !tx_ready) && cnt < 2000) begin @(posedge clk); #1; cnt++; end
      chk("drain_idle", 32'({busy, tx_ready}), 32'b01);
      repeat (5) @(posedge clk); #1;
      chk("all_words_received", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/spi_word_master.md
SPI_WORD_MASTER -- requirements
Module: spi_word_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, meaning system clocks per sck half-period (legal range 2..255).
REQ-002 SHALL have parameter WORD_W, default 16, meaning bits per frame.
REQ-003 SHALL have parameter GAP_HP, default 2, meaning sck half-periods with cs low between frames (legal range 1..15).
REQ-004 SHALL have port: clk  input  1  system clock; all logic is on its rising edge.
REQ-005 SHALL have port: reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port: tx_valid  input  1  word offered on tx_data.
REQ-007 SHALL have port: tx_data  input  WORD_W  word to transmit, MSB first.
REQ-008 SHALL have port: tx_ready  output  1  block can accept a word this cycle.
REQ-009 SHALL have port: sck  output  1  serial clock; idles low.
REQ-010 SHALL have port: sdo  output  1  serial data to the receiver's sdi.
REQ-011 SHALL have port: cs  output  1  frame select, active-high: high for the whole frame.
REQ-012 SHALL have port: done  output  1  one-cycle pulse when a frame completes.
REQ-013 SHALL have port: busy  output  1  high while not in IDLE.

Function
REQ-014 SHALL use states IDLE, LEAD, HIGH, LOW and GAP, plus a one-entry holding buffer (buf_data, buf_full).
REQ-015 SHALL accept a word on any cycle with tx_valid && tx_ready; tx_ready SHALL equal !buf_full.
REQ-016 In IDLE with buf_full=0, an accepted word SHALL load the shift register directly and move to LEAD on the next edge.
REQ-017 In any other state, or in IDLE with buf_full=1, an accepted word SHALL go into the buffer and set buf_full.
REQ-018 In IDLE with buf_full=1, the buffer SHALL move to the shift register and clear buf_full, and the FSM SHALL go to LEAD.
REQ-019 LEAD: cs=1, sck=0, sdo=shift[WORD_W-1]; it SHALL last CLK_DIV cycles and then go to HIGH.
REQ-020 HIGH: sck=1 for CLK_DIV cycles while sdo is held stable; the receiver samples on the sck rising edge. The FSM SHALL then go to LOW.
REQ-021 LOW: sck=0 for CLK_DIV cycles. On entry to LOW, the shift register SHALL shift left one bit, so sdo changes only while sck is low.
REQ-022 After the LOW phase of bit WORD_W-1, the FSM SHALL go to GAP with cs=0, sdo=0 and sck=0, and done=1 for exactly that first GAP cycle.
REQ-023 cs SHALL therefore be high for exactly (2*WORD_W+1)*CLK_DIV cycles per frame, with exactly WORD_W sck rising edges.
REQ-024 GAP SHALL last GAP_HP*CLK_DIV cycles and then go to IDLE; a buffered word SHALL start per REQ-018.
REQ-025 Minimum back-to-back cs-low time: GAP_HP*CLK_DIV cycles in GAP plus 1 IDLE cycle.
REQ-026 The bit counter SHALL be $clog2(WORD_W)+1 bits wide and the divider counter 8 bits wide; counters SHALL reset to 0 at each phase change.
REQ-027 An offer while tx_ready=0 SHALL be ignored; tx_data need not be held after acceptance.
REQ-028 busy SHALL be 1 in LEAD, HIGH, LOW and GAP, and 0 in IDLE.

Reset
REQ-029 reset SHALL have priority over all other inputs.
REQ-030 On reset: state=IDLE, sck=0, sdo=0, cs=0, done=0, busy=0, buf_full=0, tx_ready=1, all counters 0.
REQ-031 Reset mid-frame SHALL abort the frame: cs drops on the next edge, no done pulse is issued, and the buffer is discarded.

Verification
REQ-032 Reset, then tx_data=16'h8000 with a one-cycle valid (CLK_DIV=4) -> cs high for 132 cycles; sdo=1 only from LEAD through the first HIGH; 16 sck rising edges; done pulse when cs falls; a sampling receiver model reads 0x8000.
REQ-033 Send 16'h4000, then 16'h2000 -> the receiver model reads 0x4000 then 0x2000; sdo is stable for the whole time sck=1 (checker on every sck high cycle).
REQ-034 Offer 16'hA5C3 during frame 1, then a third word while buf_full=1 -> tx_ready=0 during the third offer; frame 2 = 0xA5C3 starts after 9 cs-low cycles (8 GAP + 1 IDLE); the third word is not transmitted.
REQ-035 Assert reset at the 8th sck rising edge of a frame, with a word in the buffer -> next cycle cs=0, sck=0, tx_ready=1; no done pulse; no further frame starts without a new offer.
REQ-036 tx_data=16'hFFFF then 16'h0000 -> the receiver reads both exactly; done is high for exactly 1 cycle per frame; busy is low only in IDLE.
